// File: rtl/flt_pds2_axi4s_src.sv
// AXI4-Stream operand source for flt_pds2: a bounded frame of clamped pseudo-random floats from
// a 32-bit Galois LFSR. Define FLT_PDS2_SPECIAL_EN to inject +0/+inf/qNaN/denormal every 16th beat.
module flt_pds2_axi4s_src #(
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned MAN_WIDTH   = 23,
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned REPEAT_NUM  = 1000,
    parameter logic [31:0] LFSR_SEED   = 32'h1234_5678,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic                   i_aclk,
    input  logic                   i_areset,
    input  logic                   i_start,
    output logic [TDATA_WIDTH-1:0] o_axi4s_a_tdata,
    output logic                   o_axi4s_a_tvalid,
    input  logic                   i_axi4s_a_tready,
    output logic                   o_axi4s_a_tlast,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [15:0]            o_beat_cnt
);

    localparam int unsigned WIDTH     = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [15:0] LAST_BEAT = 16'(REPEAT_NUM - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d, lfsr_next;
    logic [15:0]    beat_cnt_q, beat_cnt_d;
    logic [15:0]    gap_cnt_q, gap_cnt_d;
    logic           handshake;
    logic [WIDTH-1:0]     raw;
    logic [EXP_WIDTH-1:0] exp_raw, exp_clamped;
    logic [WIDTH-1:0]     word;

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q    <= StIdle;
            lfsr_q     <= LFSR_SEED;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Exponent clamped away from zero and all-ones: never zero, denormal, inf or NaN.
    always_comb begin
        raw     = lfsr_q[WIDTH-1:0];
        exp_raw = raw[WIDTH-2:MAN_WIDTH];
        if (exp_raw == '0) begin
            exp_clamped = EXP_WIDTH'(1);
        end else if (&exp_raw) begin
            exp_clamped = {{(EXP_WIDTH-1){1'b1}}, 1'b0};
        end else begin
            exp_clamped = exp_raw;
        end
        word = {raw[WIDTH-1], exp_clamped, raw[MAN_WIDTH-1:0]};
`ifdef FLT_PDS2_SPECIAL_EN
        if (beat_cnt_q[3:0] == 4'hF) begin
            case (beat_cnt_q[5:4])
                2'd0:    word = '0;
                2'd1:    word = {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
                2'd2:    word = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
                default: word = WIDTH'(1);
            endcase
        end
`endif
    end

    always_comb begin
        o_axi4s_a_tvalid = (state_q == StSend);
        o_axi4s_a_tlast  = o_axi4s_a_tvalid && (beat_cnt_q == LAST_BEAT);
        o_busy           = (state_q == StSend) || (state_q == StGap);
        o_done           = (state_q == StDone);
        o_beat_cnt       = beat_cnt_q;
        o_axi4s_a_tdata  = '0;
        if (o_axi4s_a_tvalid) begin
            o_axi4s_a_tdata[WIDTH-1:0] = word;
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        handshake  = o_axi4s_a_tvalid && i_axi4s_a_tready;
        lfsr_next  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
        case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    state_d    = StSend;
                    lfsr_d     = LFSR_SEED;
                    beat_cnt_d = '0;
                end
            end
            StSend: begin
                if (handshake) begin
                    lfsr_d     = lfsr_next;
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_flt_pds2_axi4s_src.sv
// Directed bench for flt_pds2_axi4s_src: frame sequence, backpressure, gaps, clamping, reset.
module tb_flt_pds2_axi4s_src;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived words for the default seed (LFSR shifted right, mask on lsb=1).
    logic [31:0] beats [8] = '{32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E, 32'h0246_8ACF,
                               32'h8103_4564, 32'h4081_A2B2, 32'h2040_D159, 32'h9000_68AF};

    // dut_a: REPEAT_NUM=8, no gap
    logic start_a = 0, rdy_a = 0;
    logic [31:0] data_a;
    logic valid_a, last_a, busy_a, done_a;
    logic [15:0] cnt_a;
    flt_pds2_axi4s_src #(.REPEAT_NUM(8)) dut_a (
        .i_aclk(clk), .i_areset(rst), .i_start(start_a), .o_axi4s_a_tdata(data_a),
        .o_axi4s_a_tvalid(valid_a), .i_axi4s_a_tready(rdy_a), .o_axi4s_a_tlast(last_a),
        .o_busy(busy_a), .o_done(done_a), .o_beat_cnt(cnt_a));

    // dut_g: REPEAT_NUM=4, GAP_CYCLES=2
    logic start_g = 0;
    logic [31:0] data_g;
    logic valid_g, last_g, busy_g, done_g;
    logic [15:0] cnt_g;
    flt_pds2_axi4s_src #(.REPEAT_NUM(4), .GAP_CYCLES(2)) dut_g (
        .i_aclk(clk), .i_areset(rst), .i_start(start_g), .o_axi4s_a_tdata(data_g),
        .o_axi4s_a_tvalid(valid_g), .i_axi4s_a_tready(1'b1), .o_axi4s_a_tlast(last_g),
        .o_busy(busy_g), .o_done(done_g), .o_beat_cnt(cnt_g));

    // dut_s/dut_t: single-beat frames with exponent-clamping seeds
    logic start_s = 0;
    logic [31:0] data_s, data_t;
    logic valid_s, last_s, busy_s, done_s, valid_t, last_t, busy_t, done_t;
    logic [15:0] cnt_s, cnt_t;
    flt_pds2_axi4s_src #(.REPEAT_NUM(1), .LFSR_SEED(32'h7F80_0000)) dut_s (
        .i_aclk(clk), .i_areset(rst), .i_start(start_s), .o_axi4s_a_tdata(data_s),
        .o_axi4s_a_tvalid(valid_s), .i_axi4s_a_tready(1'b1), .o_axi4s_a_tlast(last_s),
        .o_busy(busy_s), .o_done(done_s), .o_beat_cnt(cnt_s));
    flt_pds2_axi4s_src #(.REPEAT_NUM(1), .LFSR_SEED(32'h8000_0001)) dut_t (
        .i_aclk(clk), .i_areset(rst), .i_start(start_s), .o_axi4s_a_tdata(data_t),
        .o_axi4s_a_tvalid(valid_t), .i_axi4s_a_tready(1'b1), .o_axi4s_a_tlast(last_t),
        .o_busy(busy_t), .o_done(done_t), .o_beat_cnt(cnt_t));

`ifdef FLT_PDS2_SPECIAL_EN
    logic start_x = 0;
    logic [31:0] data_x;
    logic valid_x, last_x, busy_x, done_x;
    logic [15:0] cnt_x;
    flt_pds2_axi4s_src #(.REPEAT_NUM(64)) dut_x (
        .i_aclk(clk), .i_areset(rst), .i_start(start_x), .o_axi4s_a_tdata(data_x),
        .o_axi4s_a_tvalid(valid_x), .i_axi4s_a_tready(1'b1), .o_axi4s_a_tlast(last_x),
        .o_busy(busy_x), .o_done(done_x), .o_beat_cnt(cnt_x));

    function automatic logic [31:0] model_word(input logic [31:0] l);
        logic [7:0] e;
        e = l[30:23];
        if (e == 8'h00) e = 8'h01;
        else if (e == 8'hFF) e = 8'hFE;
        return {l[31], e, l[22:0]};
    endfunction
`endif

    initial begin
        #12;
        check_eq("rst_valid", {31'd0, valid_a}, 32'd0);
        check_eq("rst_data", data_a, 32'd0);
        check_eq("rst_last", {31'd0, last_a}, 32'd0);
        check_eq("rst_busy_done", {30'd0, busy_a, done_a}, 32'd0);
        check_eq("rst_cnt", {16'd0, cnt_a}, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back frame
        rdy_a = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("b2b_valid%0d", i), {31'd0, valid_a}, 32'd1);
            check_eq($sformatf("b2b_data%0d", i), data_a, beats[i]);
            check_eq($sformatf("b2b_last%0d", i), {31'd0, last_a}, {31'd0, i == 7});
            check_eq($sformatf("b2b_cnt%0d", i), {16'd0, cnt_a}, i);
            step();
        end
        check_eq("b2b_end_valid", {31'd0, valid_a}, 32'd0);
        check_eq("b2b_end_done", {31'd0, done_a}, 32'd1);
        check_eq("b2b_end_cnt", {16'd0, cnt_a}, 32'd8);
        step();
        check_eq("done_hold", {31'd0, done_a}, 32'd1);

        // Backpressure on beat 3 (restart from DONE)
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check_eq("restart_done_clr", {31'd0, done_a}, 32'd0);
        for (int i = 0; i < 3; i++) step();
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("bp_valid", {31'd0, valid_a}, 32'd1);
            check_eq("bp_data", data_a, beats[3]);
            check_eq("bp_last", {31'd0, last_a}, 32'd0);
            check_eq("bp_cnt", {16'd0, cnt_a}, 32'd3);
        end
        rdy_a = 1'b1;
        for (int i = 3; i < 8; i++) begin
            check_eq($sformatf("bp_resume_data%0d", i), data_a, beats[i]);
            check_eq($sformatf("bp_resume_last%0d", i), {31'd0, last_a}, {31'd0, i == 7});
            step();
        end
        check_eq("bp_done", {31'd0, done_a}, 32'd1);

        // Start held high during SEND must not restart; then reset at beat 3
        start_a = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ign_start_data%0d", i), data_a, beats[i]);
            step();
        end
        check_eq("pre_rst_data", data_a, beats[3]);
        start_a = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", {31'd0, valid_a}, 32'd0);
        check_eq("arst_cnt", {16'd0, cnt_a}, 32'd0);
        check_eq("arst_data", data_a, 32'd0);
        check_eq("arst_busy", {31'd0, busy_a}, 32'd0);
        step();
        rst = 1'b0;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("replay_data%0d", i), data_a, beats[i]);
            step();
        end

        // Gap pattern: 1,0,0,1,0,0,1,0,0,1 then DONE with no trailing gap
        start_g = 1'b1;
        step();
        start_g = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_eq($sformatf("gap_valid%0d", c), {31'd0, valid_g}, {31'd0, (c % 3) == 0});
            if ((c % 3) == 0) begin
                check_eq($sformatf("gap_data%0d", c), data_g, beats[c / 3]);
                check_eq($sformatf("gap_last%0d", c), {31'd0, last_g}, {31'd0, c == 9});
            end else begin
                check_eq($sformatf("gap_busy%0d", c), {31'd0, busy_g}, 32'd1);
            end
            step();
        end
        check_eq("gap_done", {31'd0, done_g}, 32'd1);
        check_eq("gap_cnt", {16'd0, cnt_g}, 32'd4);

        // Exponent clamping, single-beat frames
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        check_eq("clamp_hi_data", data_s, 32'h7F00_0000);
        check_eq("clamp_hi_last", {31'd0, last_s}, 32'd1);
        check_eq("clamp_lo_data", data_t, 32'h8080_0001);
        check_eq("clamp_lo_last", {31'd0, last_t}, 32'd1);
        step();
        check_eq("one_done", {30'd0, done_s, done_t}, 32'd3);
        check_eq("one_cnt", {cnt_s, cnt_t}, {16'd1, 16'd1});

`ifdef FLT_PDS2_SPECIAL_EN
        begin
            logic [31:0] l;
            logic [31:0] specials [4] = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000,
                                          32'h0000_0001};
            l = 32'h1234_5678;
            start_x = 1'b1;
            step();
            start_x = 1'b0;
            for (int i = 0; i < 64; i++) begin
                if (i == 15 || i == 31 || i == 47 || i == 63)
                    check_eq($sformatf("spec_data%0d", i), data_x, specials[i / 16]);
                if (i == 16)
                    check_eq("spec_beat16", data_x, model_word(l));
                if (i == 63)
                    check_eq("spec_last", {31'd0, last_x}, 32'd1);
                l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
                step();
            end
            check_eq("spec_done", {31'd0, done_x}, 32'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flt_pds2_axi4s_src.md
Name: flt_pds2_axi4s_src

Overview:
- AXI4-Stream operand source (transmitter) for the flt_pds2 floating-point core; it drives the operand channel that the core consumes.
- Generates a bounded frame of pseudo-random single-format floats from a 32-bit Galois LFSR, honours tready backpressure, and marks the final beat with tlast.
- Used by on-board self-test tops and benches as the reproducible stimulus end of the operand interface.

Parameters:
- EXP_WIDTH, 8, exponent field width
- MAN_WIDTH, 23, mantissa field width (WIDTH = 1+EXP_WIDTH+MAN_WIDTH)
- TDATA_WIDTH, 32, WIDTH rounded up to a multiple of 8
- REPEAT_NUM, 1000, beats per frame, range 1..65535
- LFSR_SEED, 32'h1234_5678, nonzero LFSR reset/start value
- GAP_CYCLES, 0, idle cycles (tvalid low) inserted after each accepted non-last beat

Ports:
- i_aclk  in  1  clock; all logic rising-edge
- i_areset  in  1  asynchronous, active-high reset
- i_start  in  1  frame start request; sampled in IDLE or DONE only
- o_axi4s_a_tdata  out  TDATA_WIDTH  operand; bits above WIDTH are 0
- o_axi4s_a_tvalid  out  1  operand valid
- i_axi4s_a_tready  in  1  sink ready
- o_axi4s_a_tlast  out  1  high on beat REPEAT_NUM-1
- o_busy  out  1  high in SEND/GAP
- o_done  out  1  high in DONE, held until next start
- o_beat_cnt  out  16  accepted beats in the current frame

Behaviour:
- Reset values (async assert, sync release): state IDLE; tvalid, tlast, busy, done = 0; beat_cnt = 0; tdata = 0; lfsr = LFSR_SEED.
- States: IDLE, SEND, GAP, DONE.
- Start: i_start=1 in IDLE/DONE at edge k:
  - lfsr reloads LFSR_SEED; beat_cnt clears; done clears.
  - State becomes SEND with tvalid=1 from cycle k+1.
- i_start in SEND/GAP is ignored.
- Word formation: raw = lfsr[WIDTH-1:0].
  - sign = raw[WIDTH-1], man = raw[MAN_WIDTH-1:0].
  - exp = raw exponent field, clamped: 0 becomes 1, all-ones becomes all-ones minus 1. No zero, denormal, inf or NaN in normal mode.
  - Default seed gives first word 0x12345678.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1 (mask 0x80200003); shifts right, XORs the mask when lsb=1.
  - Advances exactly once per handshake (tvalid & tready); never otherwise.
- Handshake: once tvalid=1, tdata and tlast stay stable until tready=1. tvalid never drops without a handshake (except reset).
- On each handshake beat_cnt increments. Next state:
  - Last beat (beat_cnt == REPEAT_NUM-1 before increment): DONE; tvalid=0 next cycle.
  - Else, GAP_CYCLES>0: GAP for exactly GAP_CYCLES cycles with tvalid=0, then SEND with the next word.
  - Else: stay in SEND; the next word is presented the following cycle, giving back-to-back beats at tready=1.
- tlast is combinational on the registered beat_cnt; it is high only while the last beat is presented.
- REPEAT_NUM=1: the single beat carries tlast.
- beat_cnt saturates at REPEAT_NUM; it holds in DONE until the next start.
- Reset mid-frame: tvalid drops immediately (async) and all state returns to reset values. A subsequent start reproduces the identical sequence.

Optional Feature:
- Macro FLT_PDS2_SPECIAL_EN.
- Defined: on beats with beat_cnt[3:0]==15, tdata is replaced by a special value. Values cycle by beat_cnt[5:4]: 0→0x00000000 (+0), 1→0x7F800000 (+inf), 2→0x7FC00000 (qNaN), 3→0x00000001 (min denormal).
  - Values are shown for the default widths; for other widths use the equivalent field patterns.
  - The LFSR still advances on these beats, so the non-special words match the non-special build.
- Undefined: only clamped LFSR words are emitted; no special-value logic is synthesised.

Test Plan:
- REPEAT_NUM=8, tready=1, pulse start → 8 consecutive valid cycles; beat 0 = 0x12345678; tlast only on beat 7; done=1 and beat_cnt=8 the cycle after.
- Drop tready for 5 cycles while tvalid=1 on beat 3 → tdata and tlast unchanged, beat_cnt stays 3, LFSR unchanged; resumes on tready=1.
- GAP_CYCLES=2, tready=1 → tvalid pattern 1,0,0,1,0,0…; final beat goes straight to DONE with no gap.
- LFSR_SEED=32'h7F80_0000 → first exp 0xFE, word 0x7F000000. LFSR_SEED=32'h8000_0001 → first word 0x80800001 (exp 0 clamped to 1).
- Assert i_areset at beat 3 → tvalid=0 in the same cycle, beat_cnt=0; restart reproduces beats 0..3 bit-exactly; i_start during SEND has no effect.
- FLT_PDS2_SPECIAL_EN, REPEAT_NUM=64 → beat 15 = 0x00000000, 31 = 0x7F800000, 47 = 0x7FC00000, 63 = 0x00000001 with tlast; beat 16 equals beat 16 of the non-special build.
